aes128_ctrl_fsm: RTL and testbench

Control sequencer for the AES-128 encryption core. It expands a newly loaded 128-bit key into eleven round-key registers (B0..B10) and steps one plaintext block through the initial AddRoundKey, nine full rounds and the final round. It has no datapath of its own: it drives only the mux selects and register enables of the round/key datapath.

---
 rtl/aes128_ctrl_fsm.sv | 167 ++++++++++++++++
 tb/tb_aes128_ctrl_fsm.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/aes128_ctrl_fsm.sv
// Moore control sequencer for the AES-128 core: runs the key schedule into B0..B10 and
// walks one block through ARK0, nine full rounds and the final round.
module aes128_ctrl_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] keyInit,
  output logic       keyChange,
  output logic       sel1,
  output logic       sel2,
  output logic       sel3,
  output logic       sel4,
  output logic       selCypher,
  output logic       buffer1en,
  output logic       buffer2en,
  output logic       buffer3en,
  output logic       buffer4en,
  output logic       buffer5en,
  output logic       buffer7en,
  output logic       buffer8en,
  output logic       buffer9en,
  output logic       B0en,
  output logic       B1en,
  output logic       B2en,
  output logic       B3en,
  output logic       B4en,
  output logic       B5en,
  output logic       B6en,
  output logic       B7en,
  output logic       B8en,
  output logic       B9en,
  output logic       B10en
);

  typedef enum logic [3:0] {
    IDLE, KEY_LOAD, KEY_EXP, PT_LOAD, ARK0, SB, SR, MC, ARK, DONE
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  rnd, rnd_nxt;
  logic        key_valid, key_valid_nxt;
  logic [10:0] ben;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rnd       <= 4'd0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      rnd       <= rnd_nxt;
      key_valid <= key_valid_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    rnd_nxt       = rnd;
    key_valid_nxt = key_valid;
    keyChange = 1'b0;
    sel1      = 1'b0;
    sel2      = 1'b0;
    sel3      = 1'b0;
    sel4      = 1'b0;
    selCypher = 1'b0;
    buffer1en = 1'b0;
    buffer2en = 1'b0;
    buffer3en = 1'b0;
    buffer4en = 1'b0;
    buffer5en = 1'b0;
    buffer7en = 1'b0;
    buffer8en = 1'b0;
    buffer9en = 1'b0;
    ben       = 11'd0;
    case (state)
      IDLE: begin
        rnd_nxt = 4'd0;
        // Key load has priority; a simultaneous start is dropped, not queued.
        if (keyInit[0]) begin
          state_nxt     = KEY_LOAD;
          key_valid_nxt = 1'b0;
        end else if (keyInit[1] && key_valid) begin
          state_nxt = PT_LOAD;
        end
      end
      KEY_LOAD: begin
        buffer7en = 1'b1;
        keyChange = 1'b1;
        ben       = 11'd1;
        state_nxt = KEY_EXP;
        rnd_nxt   = 4'd1;
      end
      KEY_EXP: begin
        buffer8en = 1'b1;
        keyChange = 1'b1;
        sel1      = 1'b1;
        ben       = 11'd1 << rnd;
        if (rnd == 4'd10) begin
          state_nxt     = IDLE;
          rnd_nxt       = 4'd0;
          key_valid_nxt = 1'b1;
        end else begin
          rnd_nxt = rnd + 4'd1;
        end
      end
      PT_LOAD: begin
        buffer1en = 1'b1;
        state_nxt = ARK0;
      end
      ARK0: begin
        buffer2en = 1'b1;
        state_nxt = SB;
        rnd_nxt   = 4'd1;
      end
      SB: begin
        buffer3en = 1'b1;
        selCypher = 1'b1;
        state_nxt = SR;
      end
      SR: begin
        buffer4en = 1'b1;
        selCypher = 1'b1;
        // The final round skips MixColumns.
        state_nxt = (rnd < 4'd10) ? MC : ARK;
      end
      MC: begin
        buffer5en = 1'b1;
        selCypher = 1'b1;
        state_nxt = ARK;
      end
      ARK: begin
        buffer2en = 1'b1;
        sel2      = 1'b1;
        selCypher = 1'b1;
        sel3      = (rnd == 4'd10);
        if (rnd < 4'd10) begin
          state_nxt = SB;
          rnd_nxt   = rnd + 4'd1;
        end else begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        buffer9en = 1'b1;
        sel4      = 1'b1;
        state_nxt = IDLE;
        rnd_nxt   = 4'd0;
      end
      default: begin
        state_nxt = IDLE;
        rnd_nxt   = 4'd0;
      end
    endcase
  end

  assign B0en  = ben[0];
  assign B1en  = ben[1];
  assign B2en  = ben[2];
  assign B3en  = ben[3];
  assign B4en  = ben[4];
  assign B5en  = ben[5];
  assign B6en  = ben[6];
  assign B7en  = ben[7];
  assign B8en  = ben[8];
  assign B9en  = ben[9];
  assign B10en = ben[10];

endmodule

// File: tb/tb_aes128_ctrl_fsm.sv
// Scoreboard bench for aes128_ctrl_fsm: a command-level model pushes the expected
// per-cycle output word sequence; a negedge monitor pops and compares.
module tb_aes128_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] keyInit;
  logic keyChange, sel1, sel2, sel3, sel4, selCypher;
  logic buffer1en, buffer2en, buffer3en, buffer4en, buffer5en, buffer7en, buffer8en, buffer9en;
  logic B0en, B1en, B2en, B3en, B4en, B5en, B6en, B7en, B8en, B9en, B10en;

  aes128_ctrl_fsm dut (
    .clk(clk), .reset(reset), .keyInit(keyInit),
    .keyChange(keyChange), .sel1(sel1), .sel2(sel2), .sel3(sel3), .sel4(sel4),
    .selCypher(selCypher),
    .buffer1en(buffer1en), .buffer2en(buffer2en), .buffer3en(buffer3en),
    .buffer4en(buffer4en), .buffer5en(buffer5en), .buffer7en(buffer7en),
    .buffer8en(buffer8en), .buffer9en(buffer9en),
    .B0en(B0en), .B1en(B1en), .B2en(B2en), .B3en(B3en), .B4en(B4en), .B5en(B5en),
    .B6en(B6en), .B7en(B7en), .B8en(B8en), .B9en(B9en), .B10en(B10en)
  );

  always #5 clk = ~clk;

  // Output word layout: control bits on top, round-key enables B10..B0 at the bottom.
  localparam int KC = 24, S1 = 23, S2 = 22, S3 = 21, S4 = 20, SC = 19;
  localparam int BF1 = 18, BF2 = 17, BF3 = 16, BF4 = 15, BF5 = 14, BF7 = 13, BF8 = 12, BF9 = 11;

  logic [24:0] obs;
  assign obs = {keyChange, sel1, sel2, sel3, sel4, selCypher,
                buffer1en, buffer2en, buffer3en, buffer4en, buffer5en,
                buffer7en, buffer8en, buffer9en,
                B10en, B9en, B8en, B7en, B6en, B5en, B4en, B3en, B2en, B1en, B0en};

  logic [24:0] exp_q[$];
  bit          model_kv;
  int          checks = 0;
  int          fails  = 0;

  function automatic logic [24:0] bit_at(input int pos);
    logic [24:0] w;
    w = '0;
    w[pos] = 1'b1;
    return w;
  endfunction

  task automatic push_key_schedule();
    exp_q.push_back(bit_at(KC) | bit_at(BF7) | bit_at(0));
    for (int i = 1; i <= 10; i++)
      exp_q.push_back(bit_at(KC) | bit_at(S1) | bit_at(BF8) | bit_at(i));
  endtask

  task automatic push_encrypt();
    exp_q.push_back(bit_at(BF1));
    exp_q.push_back(bit_at(BF2));
    for (int r = 1; r <= 10; r++) begin
      exp_q.push_back(bit_at(BF3) | bit_at(SC));
      exp_q.push_back(bit_at(BF4) | bit_at(SC));
      if (r < 10) exp_q.push_back(bit_at(BF5) | bit_at(SC));
      exp_q.push_back(bit_at(BF2) | bit_at(S2) | bit_at(SC) | (r == 10 ? bit_at(S3) : 25'd0));
    end
    exp_q.push_back(bit_at(BF9) | bit_at(S4));
  endtask

  // Command semantics as seen from IDLE.
  task automatic model_cmd(input logic [3:0] cmd);
    if (cmd[0]) begin
      push_key_schedule();
      model_kv = 1'b1;
    end else if (cmd[1] && model_kv) begin
      push_encrypt();
    end
  endtask

  always @(negedge clk) begin
    logic [24:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 25'd0;
    checks++;
    if (obs !== e) begin
      fails++;
      $display("FAIL outputs @%0t: got %h expected %h", $time, obs, e);
    end
  end

  // Called at posedge+1 with the DUT in IDLE.
  task automatic issue(input logic [3:0] cmd);
    keyInit = cmd;
    @(posedge clk); #1;
    keyInit = 4'd0;
    model_cmd(cmd);
  endtask

  // Runs until the expected sequence drains, driving junk that must be ignored.
  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      keyInit = 4'($urandom);
      @(posedge clk); #1;
      n++;
    end
    keyInit = 4'd0;
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL wait_idle: got %0d pending words expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  function automatic logic [3:0] rand_cmd();
    logic [3:0] c;
    int r;
    r = $urandom_range(0, 9);
    c = 4'($urandom) & 4'b1100;
    if (r <= 1)      c[1:0] = 2'b01;
    else if (r == 2) c[1:0] = 2'b11;
    else if (r <= 7) c[1:0] = 2'b10;
    return c;
  endfunction

  initial begin
    model_kv = 1'b0;
    keyInit  = 4'd0;
    reset    = 1'b1;
    #12 reset = 1'b0;
    repeat (100) @(posedge clk);
    #1;

    issue(4'b0010);
    repeat (5) begin @(posedge clk); #1; end
    issue(4'b0001);
    wait_idle();
    issue(4'b0010);
    wait_idle();
    issue(4'b0011);
    wait_idle();
    repeat (3) begin @(posedge clk); #1; end

    for (int k = 0; k < 40; k++) begin
      issue(rand_cmd());
      wait_idle();
    end

    // Reset in the middle of round 5, then confirm the key is forgotten.
    issue(4'b0001);
    wait_idle();
    issue(4'b0010);
    repeat (19) begin @(posedge clk); #1; end
    reset = 1'b1;
    exp_q.delete();
    model_kv = 1'b0;
    #1;
    checks++;
    if (obs !== 25'd0) begin
      fails++;
      $display("FAIL reset_async: got %h expected %h", obs, 25'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    issue(4'b0010);
    repeat (60) begin @(posedge clk); #1; end
    issue(4'b0001);
    wait_idle();
    issue(4'b0010);
    wait_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
